// File: rtl/branch_sequencer.sv
// Relative-branch sequencer for a 6502-style core: fetches the signed offset,
// evaluates the condition from P and produces the next PC with cycle-accurate penalties.
module branch_sequencer #(
  parameter int unsigned WAIT_MAX   = 15,
  parameter bit          PENALTY_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  opcode,
  input  logic [7:0]  flags,
  input  logic [15:0] pc_in,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic        busy,
  output logic        taken,
  output logic        page_cross,
  output logic [15:0] pc_next,
  output logic        pc_load,
  output logic        done,
  output logic        illegal,
  output logic        timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EVAL,
    S_ADD_LO,
    S_FIX_HI,
    S_DONE
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_e      state_q,    state_d;
  logic [2:0]  op_q,       op_d;       // opcode[7:5]: flag select and polarity
  logic [3:0]  flags_q,    flags_d;    // {N, V, C, Z}
  logic [15:0] addr_q,     addr_d;
  logic [15:0] base_q,     base_d;
  logic [7:0]  offset_q,   offset_d;
  logic [7:0]  wait_q,     wait_d;
  logic [15:0] pc_next_q,  pc_next_d;
  logic        taken_q,    taken_d;
  logic        cross_q,    cross_d;
  logic        illegal_q,  illegal_d;
  logic        timeout_q,  timeout_d;

  // D, B, I and bit 5 of P play no part in branch conditions.
  logic unused_flags;
  assign unused_flags = ^flags[5:2];

  logic       is_branch;
  logic       cond_flag;
  logic       cond_taken;
  logic [8:0] lo_sum;
  logic       fwd_cross;
  logic       bwd_cross;
  logic       any_cross;
  logic [7:0] hi_fix;
  logic [15:0] target;

  assign is_branch = (opcode[4:0] == 5'b10000);

  always_comb begin
    case (op_q[2:1])
      2'b00:   cond_flag = flags_q[3];
      2'b01:   cond_flag = flags_q[2];
      2'b10:   cond_flag = flags_q[1];
      default: cond_flag = flags_q[0];
    endcase
  end

  assign cond_taken = (cond_flag == op_q[0]);

  // Low-byte add with the carry telling us which way (if any) the page moved.
  assign lo_sum    = {1'b0, base_q[7:0]} + {1'b0, offset_q};
  assign fwd_cross = ~offset_q[7] &  lo_sum[8];
  assign bwd_cross =  offset_q[7] & ~lo_sum[8];
  assign any_cross = fwd_cross | bwd_cross;
  assign hi_fix    = fwd_cross ? (base_q[15:8] + 8'd1) : (base_q[15:8] - 8'd1);
  assign target    = {(any_cross ? hi_fix : base_q[15:8]), lo_sum[7:0]};

  always_comb begin
    // NOTE: every _d defaults to its _q (pulses to 0) first, so no path through the case infers a latch.
    state_d   = state_q;
    op_d      = op_q;
    flags_d   = flags_q;
    addr_d    = addr_q;
    base_d    = base_q;
    offset_d  = offset_q;
    wait_d    = wait_q;
    pc_next_d = pc_next_q;
    taken_d   = taken_q;
    cross_d   = cross_q;
    illegal_d = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          taken_d = 1'b0;
          cross_d = 1'b0;
          if (is_branch) begin
            op_d    = opcode[7:5];
            flags_d = {flags[7], flags[6], flags[0], flags[1]};
            addr_d  = pc_in;
            wait_d  = 8'd0;
            state_d = S_FETCH;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end

      S_FETCH: begin
        if (mem_ack) begin
          offset_d = mem_data;
          base_d   = addr_q + 16'd1;
          state_d  = S_EVAL;
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_EVAL: begin
        taken_d = cond_taken;
        if (!cond_taken) begin
          pc_next_d = base_q;
          state_d   = S_DONE;
        end else if (PENALTY_EN) begin
          state_d = S_ADD_LO;
        end else begin
          pc_next_d = target;
          cross_d   = any_cross;
          state_d   = S_DONE;
        end
      end

      S_ADD_LO: begin
        if (any_cross) begin
          state_d = S_FIX_HI;
        end else begin
          pc_next_d = target;
          state_d   = S_DONE;
        end
      end

      S_FIX_HI: begin
        pc_next_d = target;
        cross_d   = 1'b1;
        state_d   = S_DONE;
      end

      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values together.
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      flags_q   <= '0;
      addr_q    <= '0;
      base_q    <= '0;
      offset_q  <= '0;
      wait_q    <= '0;
      pc_next_q <= '0;
      taken_q   <= 1'b0;
      cross_q   <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      flags_q   <= flags_d;
      addr_q    <= addr_d;
      base_q    <= base_d;
      offset_q  <= offset_d;
      wait_q    <= wait_d;
      pc_next_q <= pc_next_d;
      taken_q   <= taken_d;
      cross_q   <= cross_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign mem_rd     = (state_q == S_FETCH);
  assign mem_addr   = addr_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign pc_load    = done;
  assign taken      = taken_q;
  assign page_cross = cross_q;
  assign pc_next    = pc_next_q;
  assign illegal    = illegal_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Randomized bench for branch_sequencer: expected PC, page crossing and latency come from
// plain 16-bit arithmetic on the 6502 branch rules.
module tb_branch_sequencer;

  localparam int WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  opcode;
  logic [7:0]  flags;
  logic [15:0] pc_in;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic        busy;
  logic        taken;
  logic        page_cross;
  logic [15:0] pc_next;
  logic        pc_load;
  logic        done;
  logic        illegal;
  logic        timeout;

  int n_total = 0;
  int n_bad   = 0;

  branch_sequencer #(
    .WAIT_MAX  (WAIT_MAX),
    .PENALTY_EN(1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .opcode    (opcode),
    .flags     (flags),
    .pc_in     (pc_in),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .busy      (busy),
    .taken     (taken),
    .page_cross(page_cross),
    .pc_next   (pc_next),
    .pc_load   (pc_load),
    .done      (done),
    .illegal   (illegal),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int flag_pos(input logic [1:0] sel);
    case (sel)
      2'd0:    return 7;
      2'd1:    return 6;
      2'd2:    return 0;
      default: return 1;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_rd"},  32'(mem_rd), 0);
    check({tag, "_busy"},    32'(busy), 0);
    check({tag, "_taken"},   32'(taken), 0);
    check({tag, "_cross"},   32'(page_cross), 0);
    check({tag, "_pc_next"}, 32'(pc_next), 0);
    check({tag, "_addr"},    32'(mem_addr), 0);
    check({tag, "_pc_load"}, 32'(pc_load), 0);
    check({tag, "_done"},    32'(done), 0);
    check({tag, "_illegal"}, 32'(illegal), 0);
    check({tag, "_timeout"}, 32'(timeout), 0);
  endtask

  // One branch from start to done/timeout; ack_delay = FETCH cycles without ack before the ack.
  task automatic run_branch(input logic [7:0] op, input logic [7:0] fl, input logic [15:0] pc,
                            input logic [7:0] off, input int ack_delay,
                            output logic [15:0] got_pc, output logic got_cross, output int got_cyc);
    logic        exp_tk;
    logic [15:0] base;
    logic [15:0] tgt;
    logic        exp_x;
    logic [15:0] exp_pc;
    logic        exp_to;
    int          exp_cyc;
    int          cyc;
    int          fetch_idx;

    exp_tk  = (fl[flag_pos(op[7:6])] == op[5]);
    base    = pc + 16'd1;
    tgt     = base + {{8{off[7]}}, off};
    exp_x   = exp_tk && (tgt[15:8] != base[15:8]);
    exp_pc  = exp_tk ? tgt : base;
    exp_to  = (ack_delay >= WAIT_MAX);
    exp_cyc = exp_to ? (1 + WAIT_MAX) : (3 + ack_delay + int'(exp_tk) + int'(exp_x));

    start   = 1'b1;
    opcode  = op;
    flags   = fl;
    pc_in   = pc;
    mem_ack = 1'b0;
    tick();
    cyc       = 1;
    fetch_idx = 0;
    while (!(done || timeout) && cyc < 80) begin
      if (mem_rd && fetch_idx == 0) check("mem_addr", 32'(mem_addr), 32'(pc));
      mem_ack  = mem_rd && (fetch_idx == ack_delay);
      mem_data = mem_ack ? off : 8'($urandom);
      if (mem_rd) fetch_idx++;
      start  = 1'($urandom_range(0, 1));
      opcode = 8'($urandom);
      flags  = 8'($urandom);
      pc_in  = 16'($urandom);
      tick();
      cyc++;
    end
    start   = 1'b0;
    mem_ack = 1'b0;
    got_pc    = pc_next;
    got_cross = page_cross;
    got_cyc   = cyc;
    check("event_within_bound", 32'(done || timeout), 1);
    check("event_cycle", 32'(cyc), 32'(exp_cyc));

    if (exp_to) begin
      check("timeout_pulse", 32'(timeout), 1);
      check("timeout_no_done", 32'(done), 0);
      check("timeout_busy", 32'(busy), 0);
      check("timeout_mem_rd", 32'(mem_rd), 0);
      tick();
      check("timeout_one_cycle", 32'(timeout), 0);
    end else begin
      check("done_pulse", 32'(done), 1);
      check("pc_load", 32'(pc_load), 1);
      check("done_busy", 32'(busy), 1);
      check("taken", 32'(taken), 32'(exp_tk));
      check("page_cross", 32'(page_cross), 32'(exp_x));
      check("pc_next", 32'(pc_next), 32'(exp_pc));
      // a start during DONE must be ignored
      start  = 1'b1;
      opcode = 8'hA9;
      tick();
      start = 1'b0;
      check("done_one_cycle", 32'(done), 0);
      check("idle_after_done", 32'(busy), 0);
      check("start_in_done_ignored", 32'(illegal), 0);
      check("taken_held", 32'(taken), 32'(exp_tk));
    end
  endtask

  task automatic do_illegal(input logic [7:0] op);
    start  = 1'b1;
    opcode = op;
    tick();
    start = 1'b0;
    check("illegal_pulse", 32'(illegal), 1);
    check("illegal_busy", 32'(busy), 0);
    tick();
    check("illegal_one_cycle", 32'(illegal), 0);
    check("illegal_still_idle", 32'(busy), 0);
  endtask

  initial begin
    logic [15:0] p;
    logic        x;
    int          c;
    logic [7:0]  op;
    int          r;
    int          ad;
    int          n_done;

    reset = 1'b1; start = 1'b0; opcode = '0; flags = '0; pc_in = '0;
    mem_ack = 1'b0; mem_data = '0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // BNE, Z=0, same page
    run_branch(8'hD0, 8'h00, 16'h12F0, 8'h05, 0, p, x, c);
    check("bne_pc", 32'(p), 32'h12F6); check("bne_cross", 32'(x), 0); check("bne_cyc", 32'(c), 4);
    // BCC, C=0, forward page cross
    run_branch(8'h90, 8'h00, 16'h12FD, 8'h10, 0, p, x, c);
    check("bcc_pc", 32'(p), 32'h130E); check("bcc_cross", 32'(x), 1); check("bcc_cyc", 32'(c), 5);
    // BMI, N=1, backward page cross
    run_branch(8'h30, 8'h80, 16'h1300, 8'hF0, 0, p, x, c);
    check("bmi_pc", 32'(p), 32'h12F1); check("bmi_cross", 32'(x), 1); check("bmi_cyc", 32'(c), 5);
    // BEQ, Z=0, not taken
    run_branch(8'hF0, 8'h00, 16'h1300, 8'h40, 0, p, x, c);
    check("beq_pc", 32'(p), 32'h1301); check("beq_cyc", 32'(c), 3);
    // operand at 0xFFFF: base wraps to 0x0000
    run_branch(8'h10, 8'h00, 16'hFFFF, 8'h01, 0, p, x, c);
    check("wrap_pc", 32'(p), 32'h0001);
    // no ack at all, then ack in the last allowed FETCH cycle
    run_branch(8'hD0, 8'h00, 16'h2000, 8'h05, WAIT_MAX, p, x, c);
    run_branch(8'hD0, 8'h00, 16'h2000, 8'h05, WAIT_MAX - 1, p, x, c);
    check("late_ack_pc", 32'(p), 32'h2006);

    do_illegal(8'hA9);

    // reset in the middle of FETCH
    start = 1'b1; opcode = 8'hD0; flags = 8'h00; pc_in = 16'h4321;
    tick();
    start = 1'b0;
    check("fetch_before_reset", 32'(mem_rd), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("mid_fetch_reset");
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) n_done++;
    end
    check("no_done_after_reset", 32'(n_done), 0);
    run_branch(8'hB0, 8'h01, 16'h0480, 8'h7F, 1, p, x, c);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        op = 8'($urandom);
        if (op[4:0] == 5'b10000) op[4] = 1'b0;
        do_illegal(op);
      end else begin
        op = {3'($urandom), 5'b10000};
        r  = $urandom_range(0, 9);
        ad = (r < 6) ? 0 : (r < 8) ? $urandom_range(1, 5) : (r == 8) ? WAIT_MAX - 1 : WAIT_MAX;
        run_branch(op, 8'($urandom), 16'($urandom), 8'($urandom), ad, p, x, c);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
